// File: rtl/coverfloat_vector_packer.sv
// Cover-vector write side: packs one FP operation record per handshake into a
// canonical vector, queues it in a FIFO and streams it out with an end-of-test terminator.
module coverfloat_vector_packer #(
   parameter int OP_W   = 32,
   parameter int RM_W   = 8,
   parameter int OPND_W = 128,
   parameter int FMT_W  = 8,
   parameter int EXC_W  = 8,
   parameter int INTX_W = 32,
   parameter int INTM_W = 192,
   parameter int DEPTH  = 8,
   localparam int VEC_W = OP_W + RM_W + 4*OPND_W + 2*FMT_W + EXC_W + 1 + INTX_W + INTM_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [RM_W-1:0]   in_rm,
   input  logic [OPND_W-1:0] in_a,
   input  logic [OPND_W-1:0] in_b,
   input  logic [OPND_W-1:0] in_c,
   input  logic [FMT_W-1:0]  in_operandFmt,
   input  logic [OPND_W-1:0] in_result,
   input  logic [FMT_W-1:0]  in_resultFmt,
   input  logic [EXC_W-1:0]  in_exceptionBits,
   input  logic              in_intermS,
   input  logic [INTX_W-1:0] in_intermX,
   input  logic [INTM_W-1:0] in_intermM,
   input  logic              end_of_test,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [VEC_W-1:0]  out_vector,
   output logic              out_last,
   output logic [31:0]       vec_count,
   output logic              overflow_err,
   output logic [1:0]        state_dbg
);

   // Stream semantics (both sides): a beat transfers on the rising edge where
   // valid & ready are both high; valid never depends on ready, and an offered
   // out_vector stays stable until it is taken.

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      TERM  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [VEC_W-1:0]  mem [DEPTH];
   logic [VEC_W-1:0]  in_vector;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   assign in_vector = {in_op, in_rm, in_a, in_b, in_c, in_operandFmt, in_result,
                       in_resultFmt, in_exceptionBits, in_intermS, in_intermX, in_intermM};

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Ready is a function of registered occupancy only, so a pop never frees a slot in the same cycle.
   assign in_ready = !reset && (state == RUN) && !full;
   assign push     = in_valid && in_ready;

   assign out_valid  = (state == TERM) || (((state == RUN) || (state == DRAIN)) && !empty);
   assign out_last   = (state == TERM);
   assign out_vector = (state == TERM) ? '1 : (empty ? '0 : mem[rd_ptr]);
   assign pop        = out_valid && out_ready && !empty;

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_vector;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= RUN;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         vec_count    <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (vec_count != 32'hFFFF_FFFF) begin
               vec_count <= vec_count + 32'd1;
            end
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         case (state)
            RUN: begin
               if (end_of_test) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (empty) begin
                  state <= TERM;
               end
            end
            TERM: begin
               if (out_ready) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (in_valid) begin
                  overflow_err <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
